jtag_idcode_tap: RTL and testbench

- Minimal IEEE 1149.1 TAP controller, oversampled in the system clock domain.
- Consumes the top-level 32-bit JTAG IDCODE constant and serves it on TDO through the IDCODE data register; BYPASS is the only other register.
- Sits between the pad-side JTAG synchronizers (upstream) and the pinmux TDO driver (downstream).

---
 rtl/jtag_idcode_tap.sv | 131 +++++++++++++
 tb/tb_jtag_idcode_tap.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_idcode_tap.sv
// Minimal JTAG TAP oversampled on the system clock: IDCODE and BYPASS data registers only.
// TCK edges are detected from the synchronized pin and drive all TAP actions.
module jtag_idcode_tap #(
  parameter logic [31:0]        IdcodeValue = 32'h04F5_484D,
  parameter int unsigned        IrWidth     = 5,
  parameter logic [IrWidth-1:0] IdcodeInstr = IrWidth'(5'h01),
  parameter logic [IrWidth-1:0] BypassInstr = {IrWidth{1'b1}}
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               tck_i,
  input  logic               tms_i,
  input  logic               tdi_i,
  output logic               tdo_o,
  output logic               tdo_oe_o,
  output logic [3:0]         tap_state_o,
  output logic [IrWidth-1:0] ir_o,
  output logic               tlr_o
);

  typedef enum logic [3:0] {
    TLR      = 4'd0,  RTI    = 4'd1,  SEL_DR   = 4'd2,  CAP_DR = 4'd3,
    SH_DR    = 4'd4,  EX1_DR = 4'd5,  PAUSE_DR = 4'd6,  EX2_DR = 4'd7,
    UPD_DR   = 4'd8,  SEL_IR = 4'd9,  CAP_IR   = 4'd10, SH_IR  = 4'd11,
    EX1_IR   = 4'd12, PAUSE_IR = 4'd13, EX2_IR = 4'd14, UPD_IR = 4'd15
  } tap_state_e;

  tap_state_e         state_reg, state_next;
  logic               tck_q_reg;
  logic [IrWidth-1:0] ir_reg;
  logic [IrWidth-1:0] ir_sr_reg;
  logic [31:0]        dr_sr_reg;
  logic               byp_reg;
  logic               tdo_reg;
  logic               tdo_oe_reg;

  logic rise, fall, bypass_sel;

  assign rise = tck_i & ~tck_q_reg;
  assign fall = ~tck_i & tck_q_reg;
  // Any opcode other than IDCODE routes the data path through BYPASS.
  assign bypass_sel = (ir_reg == BypassInstr) || (ir_reg != IdcodeInstr);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= TLR;
      tck_q_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      tck_q_reg <= tck_i;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (rise) begin
      case (state_reg)
        TLR:      state_next = tms_i ? TLR    : RTI;
        RTI:      state_next = tms_i ? SEL_DR : RTI;
        SEL_DR:   state_next = tms_i ? SEL_IR : CAP_DR;
        CAP_DR:   state_next = tms_i ? EX1_DR : SH_DR;
        SH_DR:    state_next = tms_i ? EX1_DR : SH_DR;
        EX1_DR:   state_next = tms_i ? UPD_DR : PAUSE_DR;
        PAUSE_DR: state_next = tms_i ? EX2_DR : PAUSE_DR;
        EX2_DR:   state_next = tms_i ? UPD_DR : SH_DR;
        UPD_DR:   state_next = tms_i ? SEL_DR : RTI;
        SEL_IR:   state_next = tms_i ? TLR    : CAP_IR;
        CAP_IR:   state_next = tms_i ? EX1_IR : SH_IR;
        SH_IR:    state_next = tms_i ? EX1_IR : SH_IR;
        EX1_IR:   state_next = tms_i ? UPD_IR : PAUSE_IR;
        PAUSE_IR: state_next = tms_i ? EX2_IR : PAUSE_IR;
        EX2_IR:   state_next = tms_i ? UPD_IR : SH_IR;
        UPD_IR:   state_next = tms_i ? SEL_DR : RTI;
        default:  state_next = TLR;
      endcase
    end
  end

  // Register actions key off the state held before the rising-edge transition.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ir_reg     <= IdcodeInstr;
      ir_sr_reg  <= '0;
      dr_sr_reg  <= '0;
      byp_reg    <= 1'b0;
      tdo_reg    <= 1'b0;
      tdo_oe_reg <= 1'b0;
    end else begin
      if (rise) begin
        case (state_reg)
          TLR:    ir_reg <= IdcodeInstr;
          CAP_DR: begin
            if (bypass_sel) byp_reg <= 1'b0;
            else            dr_sr_reg <= IdcodeValue;
          end
          SH_DR: begin
            if (bypass_sel) byp_reg <= tdi_i;
            else            dr_sr_reg <= {tdi_i, dr_sr_reg[31:1]};
          end
          CAP_IR: ir_sr_reg <= IrWidth'(2'b01);
          SH_IR:  ir_sr_reg <= {tdi_i, ir_sr_reg[IrWidth-1:1]};
          UPD_IR: ir_reg    <= ir_sr_reg;
          default: ;
        endcase
      end
      if (fall) begin
        case (state_reg)
          SH_DR: begin
            tdo_oe_reg <= 1'b1;
            tdo_reg    <= bypass_sel ? byp_reg : dr_sr_reg[0];
          end
          SH_IR: begin
            tdo_oe_reg <= 1'b1;
            tdo_reg    <= ir_sr_reg[0];
          end
          default: begin
            tdo_oe_reg <= 1'b0;
            tdo_reg    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign tdo_o       = tdo_reg;
  assign tdo_oe_o    = tdo_oe_reg;
  assign tap_state_o = state_reg;
  assign ir_o        = ir_reg;
  assign tlr_o       = (state_reg == TLR);

endmodule

// File: tb/tb_jtag_idcode_tap.sv
// Testbench for jtag_idcode_tap: directed scans plus a random TMS/TDI walk
// checked against a table-driven TAP model with bit-queue data registers.
module tb_jtag_idcode_tap;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       tck_i = 1'b0;
  logic       tms_i = 1'b0;
  logic       tdi_i = 1'b0;
  logic       tdo_o, tdo_oe_o, tlr_o;
  logic [3:0] tap_state_o;
  logic [4:0] ir_o;

  always #5 clk = ~clk;

  jtag_idcode_tap dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .tck_i      (tck_i),
    .tms_i      (tms_i),
    .tdi_i      (tdi_i),
    .tdo_o      (tdo_o),
    .tdo_oe_o   (tdo_oe_o),
    .tap_state_o(tap_state_o),
    .ir_o       (ir_o),
    .tlr_o      (tlr_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] ID_VALUE = 32'h04F5484D;

  // Standard TAP successor table, indexed by state, for TMS=0 and TMS=1.
  int nxt0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nxt1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

  int         m_state;
  logic [4:0] m_ir;
  bit         dq[$];
  bit         iq[$];
  logic       m_tdo, m_oe;

  logic [3:0] obs_st;
  logic       obs_tdo, obs_oe;

  task automatic model_reset();
    m_state = 0;
    m_ir    = 5'h01;
    dq.delete();
    iq.delete();
    m_tdo = 1'b0;
    m_oe  = 1'b0;
  endtask

  task automatic model_rise(input bit tms, input bit tdi);
    logic [31:0] idv;
    idv = ID_VALUE;
    case (m_state)
      0: m_ir = 5'h01;
      3: begin
        dq.delete();
        if (m_ir == 5'h01) for (int i = 0; i < 32; i++) dq.push_back(idv[i]);
        else dq.push_back(1'b0);
      end
      4: begin
        void'(dq.pop_front());
        dq.push_back(tdi);
      end
      10: begin
        iq.delete();
        for (int i = 0; i < 5; i++) iq.push_back(i == 0);
      end
      11: begin
        void'(iq.pop_front());
        iq.push_back(tdi);
      end
      15: for (int i = 0; i < 5; i++) m_ir[i] = iq[i];
      default: ;
    endcase
    m_state = tms ? nxt1[m_state] : nxt0[m_state];
  endtask

  task automatic model_fall();
    m_oe  = (m_state == 4) || (m_state == 11);
    m_tdo = (m_state == 4) ? dq[0] : (m_state == 11) ? iq[0] : 1'b0;
  endtask

  task automatic tck_cycle(input bit tms, input bit tdi, input int hi, input int lo,
                           output logic [3:0] st, output logic tdo, output logic oe);
    @(negedge clk);
    tms_i = tms;
    tdi_i = tdi;
    tck_i = 1'b1;
    model_rise(tms, tdi);
    repeat (hi) @(negedge clk);
    tck_i = 1'b0;
    model_fall();
    repeat (lo) @(negedge clk);
    st  = tap_state_o;
    tdo = tdo_o;
    oe  = tdo_oe_o;
  endtask

  task automatic step(input bit tms, input bit tdi);
    tck_cycle(tms, tdi, 2, 2, obs_st, obs_tdo, obs_oe);
  endtask

  task automatic to_rti();
    repeat (5) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic read_idcode(output logic [31:0] word, output logic oe_all, output logic oe_after);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    word[0] = obs_tdo;
    oe_all  = obs_oe;
    oe_after = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      step(i == 32, 1'b0);
      if (i < 32) begin
        word[i] = obs_tdo;
        oe_all  = oe_all & obs_oe;
      end else begin
        oe_after = obs_oe;
      end
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic load_ir(input logic [4:0] v, output logic [4:0] tdo_bits);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    tdo_bits[0] = obs_tdo;
    for (int i = 0; i < 5; i++) begin
      step(i == 4, v[i]);
      if (i < 4) tdo_bits[i+1] = obs_tdo;
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic scan_bypass(output logic [3:0] bits);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    bits[0] = obs_tdo;
    step(1'b0, 1'b1); bits[1] = obs_tdo;
    step(1'b0, 1'b0); bits[2] = obs_tdo;
    step(1'b0, 1'b1); bits[3] = obs_tdo;
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tck_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    model_reset();
    @(negedge clk);
    $display("reset: state=%0d ir=%h tdo=%b oe=%b tlr=%b", tap_state_o, ir_o, tdo_o, tdo_oe_o, tlr_o);
    n_checks++; if (tap_state_o !== 4'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", tap_state_o); end
    n_checks++; if (ir_o !== 5'h01) begin n_fail++; $display("FAIL reset_ir got %h exp 01", ir_o); end
    n_checks++; if (tdo_o !== 1'b0) begin n_fail++; $display("FAIL reset_tdo got %b exp 0", tdo_o); end
    n_checks++; if (tdo_oe_o !== 1'b0) begin n_fail++; $display("FAIL reset_oe got %b exp 0", tdo_oe_o); end
    n_checks++; if (tlr_o !== 1'b1) begin n_fail++; $display("FAIL reset_tlr got %b exp 1", tlr_o); end
  endtask

  task automatic test_idcode();
    logic [31:0] w;
    logic oe_all, oe_after;
    to_rti();
    read_idcode(w, oe_all, oe_after);
    $display("idcode: word=%h oe_all=%b oe_after=%b", w, oe_all, oe_after);
    n_checks++; if (w !== ID_VALUE) begin n_fail++; $display("FAIL idcode_word got %h exp %h", w, ID_VALUE); end
    n_checks++; if (w[0] !== 1'b1) begin n_fail++; $display("FAIL idcode_first_bit got %b exp 1", w[0]); end
    n_checks++; if (oe_all !== 1'b1) begin n_fail++; $display("FAIL idcode_oe_shift got %b exp 1", oe_all); end
    n_checks++; if (oe_after !== 1'b0) begin n_fail++; $display("FAIL idcode_oe_exit got %b exp 0", oe_after); end
  endtask

  task automatic test_ir_scan();
    logic [4:0] b;
    load_ir(5'h1F, b);
    $display("ir_scan: tdo_bits=%b ir=%h", b, ir_o);
    n_checks++; if (b !== 5'b00001) begin n_fail++; $display("FAIL ir_capture_tdo got %b exp 00001", b); end
    n_checks++; if (ir_o !== 5'h1F) begin n_fail++; $display("FAIL ir_update got %h exp 1f", ir_o); end
  endtask

  task automatic test_bypass();
    logic [4:0] b;
    logic [3:0] bits;
    logic [4:0] ops[2] = '{5'h1F, 5'h07};
    for (int k = 0; k < 2; k++) begin
      load_ir(ops[k], b);
      scan_bypass(bits);
      $display("bypass: ir=%h tdo_bits(lsb first)=%b", ir_o, bits);
      n_checks++; if (ir_o !== ops[k]) begin n_fail++; $display("FAIL bypass_ir got %h exp %h", ir_o, ops[k]); end
      n_checks++; if (bits !== 4'b1010) begin n_fail++; $display("FAIL bypass_tdo got %b exp 1010", bits); end
    end
  endtask

  task automatic test_long_high();
    int changes;
    logic [3:0] prev;
    @(negedge clk);
    tms_i = 1'b1;
    tck_i = 1'b1;
    model_rise(1'b1, 1'b0);
    prev = tap_state_o;
    changes = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tap_state_o !== prev) changes++;
      prev = tap_state_o;
    end
    tck_i = 1'b0;
    model_fall();
    repeat (2) @(negedge clk);
    $display("long_high: changes=%0d state=%0d", changes, tap_state_o);
    n_checks++; if (changes !== 1) begin n_fail++; $display("FAIL long_high_advances got %0d exp 1", changes); end
    n_checks++; if (tap_state_o !== 4'd2) begin n_fail++; $display("FAIL long_high_state got %0d exp 2", tap_state_o); end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    n_checks++; if (tap_state_o !== 4'd13) begin n_fail++; $display("FAIL pause_ir_state got %0d exp 13", tap_state_o); end
    repeat (5) step(1'b1, 1'b0);
    $display("tlr_recovery: state=%0d tlr=%b", tap_state_o, tlr_o);
    n_checks++; if (tap_state_o !== 4'd0) begin n_fail++; $display("FAIL tlr_recovery_state got %0d exp 0", tap_state_o); end
    n_checks++; if (tlr_o !== 1'b1) begin n_fail++; $display("FAIL tlr_recovery_flag got %b exp 1", tlr_o); end
    step(1'b1, 1'b0);
    n_checks++; if (ir_o !== 5'h01) begin n_fail++; $display("FAIL tlr_recovery_ir got %h exp 01", ir_o); end
  endtask

  task automatic test_reset_mid_shift();
    logic [31:0] w;
    logic oe_all, oe_after;
    to_rti();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'($urandom));
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    $display("reset_mid_shift: state=%0d oe=%b", tap_state_o, tdo_oe_o);
    n_checks++; if (tap_state_o !== 4'd0) begin n_fail++; $display("FAIL mid_reset_state got %0d exp 0", tap_state_o); end
    n_checks++; if (tdo_oe_o !== 1'b0) begin n_fail++; $display("FAIL mid_reset_oe got %b exp 0", tdo_oe_o); end
    rst_i = 1'b0;
    model_reset();
    @(negedge clk);
    to_rti();
    read_idcode(w, oe_all, oe_after);
    $display("rescan: word=%h", w);
    n_checks++; if (w !== ID_VALUE) begin n_fail++; $display("FAIL rescan_word got %h exp %h", w, ID_VALUE); end
    n_checks++; if (oe_all !== 1'b1) begin n_fail++; $display("FAIL rescan_oe got %b exp 1", oe_all); end
  endtask

  task automatic test_reset_tck_high();
    @(negedge clk);
    rst_i = 1'b1;
    tms_i = 1'b0;
    tck_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    model_reset();
    model_rise(1'b0, 1'b0);
    @(negedge clk);
    $display("reset_tck_high: state=%0d", tap_state_o);
    n_checks++; if (tap_state_o !== 4'd1) begin n_fail++; $display("FAIL tck_high_release got %0d exp 1", tap_state_o); end
    tck_i = 1'b0;
    model_fall();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    logic [3:0] st;
    logic tdo, oe;
    bit tms, tdi;
    for (int n = 0; n < 400; n++) begin
      tms = ($urandom_range(0, 9) < 4);
      tdi = 1'($urandom);
      tck_cycle(tms, tdi, $urandom_range(1, 4), $urandom_range(1, 4), st, tdo, oe);
      $display("rand %0d: tms=%0d tdi=%0d state=%0d ir=%h tdo=%b oe=%b", n, tms, tdi, st, ir_o, tdo, oe);
      n_checks++; if (st !== 4'(m_state)) begin n_fail++; $display("FAIL rand_state got %0d exp %0d", st, m_state); end
      n_checks++; if (tdo !== m_tdo) begin n_fail++; $display("FAIL rand_tdo got %b exp %b", tdo, m_tdo); end
      n_checks++; if (oe !== m_oe) begin n_fail++; $display("FAIL rand_oe got %b exp %b", oe, m_oe); end
      n_checks++; if (ir_o !== m_ir) begin n_fail++; $display("FAIL rand_ir got %h exp %h", ir_o, m_ir); end
      n_checks++; if (tlr_o !== (m_state == 0)) begin n_fail++; $display("FAIL rand_tlr got %b exp %b", tlr_o, m_state == 0); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_idcode();
    test_ir_scan();
    test_bypass();
    test_long_high();
    test_reset_mid_shift();
    test_reset_tck_high();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
